// File: rtl/irq_controller8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : irq_controller8_pkg
// Purpose : Shared constants and helpers for the 8-line interrupt controller.
// Rev     : 1.0
// ============================================================================
package irq_controller8_pkg;

    localparam int NUM_IRQ   = 8;
    localparam int IRQ_IDX_W = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IRQ_IDX_W-1:0] idx);
        logic [NUM_IRQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder8.sv
`default_nettype none
// ============================================================================
// Module  : priority_encoder8
// Purpose : Combinational 8:3 priority encoder, highest set index wins.
// Rev     : 1.0
// ============================================================================
module priority_encoder8 (
    input  logic [7:0] in,
    output logic       valid,
    output logic [2:0] code
);

    always_comb begin
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in[i]) code = i[2:0];
        end
    end

    assign valid = |in;

endmodule
`default_nettype wire

// File: rtl/irq_controller8.sv
`default_nettype none
// ============================================================================
// Module  : irq_controller8
// Purpose : Captures, masks and arbitrates eight interrupt lines with req/ack
//           presentation and single in-service tracking until eoi.
// Rev     : 1.0
// ============================================================================
module irq_controller8
    import irq_controller8_pkg::*;
#(
    parameter bit                 EDGE_MODE = 1'b1,
    parameter logic [NUM_IRQ-1:0] MASK_RST  = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 mask_we,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    input  logic                 irq_ack,
    input  logic                 eoi,
    output logic                 irq_req,
    output logic [IRQ_IDX_W-1:0] irq_vec,
    output logic [NUM_IRQ-1:0]   pending,
    output logic [NUM_IRQ-1:0]   in_service,
    output logic [NUM_IRQ-1:0]   mask
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [NUM_IRQ-1:0]   r_irq_prev;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_in_service;
    logic [IRQ_IDX_W-1:0] r_irq_vec;
    logic [NUM_IRQ-1:0]   w_set;
    logic [NUM_IRQ-1:0]   w_clr;
    logic [NUM_IRQ-1:0]   w_active;
    logic                 w_enc_valid;
    logic [IRQ_IDX_W-1:0] w_enc_code;
    logic                 w_accept;

    assign w_set    = EDGE_MODE ? (irq_in & ~r_irq_prev) : irq_in;
    assign w_accept = (r_state == ST_REQ) && irq_ack;
    assign w_clr    = w_accept ? onehot(r_irq_vec) : '0;
    assign w_active = r_pending & r_mask;

    priority_encoder8 u_prienc (
        .in    (w_active),
        .valid (w_enc_valid),
        .code  (w_enc_code)
    );

    // A new event on the bit being acknowledged survives: set is OR-ed last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= MASK_RST;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (mask_we) r_mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_enc_valid) w_state_next = ST_REQ;
            ST_REQ:     if (irq_ack)     w_state_next = ST_SERVICE;
            ST_SERVICE: if (eoi)         w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // Vector is frozen once presented; no preemption while in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_vec    <= '0;
            r_in_service <= '0;
        end else begin
            if (r_state == ST_IDLE && w_enc_valid) r_irq_vec <= w_enc_code;
            if (w_accept) begin
                r_in_service <= onehot(r_irq_vec);
            end else if (r_state == ST_SERVICE && eoi) begin
                r_in_service <= '0;
            end
        end
    end

    always_comb begin
        irq_req = (r_state == ST_REQ);
    end

    assign irq_vec    = r_irq_vec;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign mask       = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller8.sv
`default_nettype none
// ============================================================================
// Module  : tb_irq_controller8
// Purpose : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_irq_controller8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;

    int vectors = 0;
    int miscompares = 0;

    irq_controller8 #(.EDGE_MODE(1'b1), .MASK_RST(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    // Behavioural model: which interrupt (if any) is offered, which is being
    // serviced, and the set of outstanding requests.
    logic [7:0] m_pend, m_mask, m_prev;
    int         m_offer;    // index offered to consumer, -1 when none
    int         m_serv;     // index in service, -1 when none
    int         m_vec;      // last offered index

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = 8'hFF; m_prev = '0;
        m_offer = -1; m_serv = -1; m_vec = 0;
    endtask

    task automatic model_edge();
        logic [7:0] newreq, clr;
        int h;
        newreq = irq_in & ~m_prev;
        clr    = '0;
        if (m_offer >= 0) begin
            if (irq_ack) begin
                clr[m_offer] = 1'b1;
                m_serv  = m_offer;
                m_offer = -1;
            end
        end else if (m_serv >= 0) begin
            if (eoi) m_serv = -1;
        end else begin
            h = highest(m_pend & m_mask);
            if (h >= 0) begin
                m_offer = h;
                m_vec   = h;
            end
        end
        m_pend = (m_pend & ~clr) | newreq;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_in;
    endtask

    // Model state is advanced with pre-edge inputs; outputs sampled 1 ns later.
    task automatic step();
        if (rst) model_reset(); else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] ins;
        ins = '0;
        if (m_serv >= 0) ins[m_serv] = 1'b1;
        chk({tag, " req"},  {7'd0, irq_req}, {7'd0, (m_offer >= 0)});
        chk({tag, " vec"},  {5'd0, irq_vec}, 8'(m_vec));
        chk({tag, " pend"}, pending, m_pend);
        chk({tag, " ins"},  in_service, ins);
        chk({tag, " mask"}, mask, m_mask);
    endtask

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic       eo;
        logic       req;
        logic [2:0] vec;
        logic [7:0] pend;
        logic [7:0] ins;
        logic [7:0] msk;
    } vec_t;

    vec_t tbl [30];

    initial begin
        //            irq    we  wd     ack  eoi | req vec pend   ins    mask
        tbl[0]  = '{8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 8'hFF};
        tbl[1]  = '{8'h02, 0, 8'h00, 0, 0,  0, 0, 8'h02, 8'h00, 8'hFF};
        tbl[2]  = '{8'h02, 0, 8'h00, 0, 0,  1, 1, 8'h02, 8'h00, 8'hFF};
        tbl[3]  = '{8'h02, 0, 8'h00, 1, 0,  0, 1, 8'h00, 8'h02, 8'hFF};
        tbl[4]  = '{8'h00, 0, 8'h00, 1, 0,  0, 1, 8'h00, 8'h02, 8'hFF};
        tbl[5]  = '{8'h00, 0, 8'h00, 0, 1,  0, 1, 8'h00, 8'h00, 8'hFF};
        tbl[6]  = '{8'h44, 0, 8'h00, 0, 0,  0, 1, 8'h44, 8'h00, 8'hFF};
        tbl[7]  = '{8'h44, 0, 8'h00, 0, 0,  1, 6, 8'h44, 8'h00, 8'hFF};
        tbl[8]  = '{8'h44, 0, 8'h00, 0, 1,  1, 6, 8'h44, 8'h00, 8'hFF};
        tbl[9]  = '{8'h44, 0, 8'h00, 1, 1,  0, 6, 8'h04, 8'h40, 8'hFF};
        tbl[10] = '{8'h44, 0, 8'h00, 0, 1,  0, 6, 8'h04, 8'h00, 8'hFF};
        tbl[11] = '{8'h44, 0, 8'h00, 0, 0,  1, 2, 8'h04, 8'h00, 8'hFF};
        tbl[12] = '{8'h44, 0, 8'h00, 1, 0,  0, 2, 8'h00, 8'h04, 8'hFF};
        tbl[13] = '{8'h00, 0, 8'h00, 0, 1,  0, 2, 8'h00, 8'h00, 8'hFF};
        tbl[14] = '{8'h00, 1, 8'h7F, 0, 0,  0, 2, 8'h00, 8'h00, 8'h7F};
        tbl[15] = '{8'h80, 0, 8'h00, 0, 0,  0, 2, 8'h80, 8'h00, 8'h7F};
        tbl[16] = '{8'h80, 0, 8'h00, 0, 0,  0, 2, 8'h80, 8'h00, 8'h7F};
        tbl[17] = '{8'h80, 1, 8'hFF, 0, 0,  0, 2, 8'h80, 8'h00, 8'hFF};
        tbl[18] = '{8'h80, 0, 8'h00, 0, 0,  1, 7, 8'h80, 8'h00, 8'hFF};
        tbl[19] = '{8'h00, 0, 8'h00, 1, 0,  0, 7, 8'h00, 8'h80, 8'hFF};
        tbl[20] = '{8'h00, 0, 8'h00, 0, 1,  0, 7, 8'h00, 8'h00, 8'hFF};
        tbl[21] = '{8'h02, 0, 8'h00, 0, 0,  0, 7, 8'h02, 8'h00, 8'hFF};
        tbl[22] = '{8'h02, 0, 8'h00, 0, 0,  1, 1, 8'h02, 8'h00, 8'hFF};
        tbl[23] = '{8'h82, 0, 8'h00, 0, 0,  1, 1, 8'h82, 8'h00, 8'hFF};
        tbl[24] = '{8'h82, 1, 8'h00, 0, 0,  1, 1, 8'h82, 8'h00, 8'h00};
        tbl[25] = '{8'h82, 1, 8'hFF, 1, 0,  0, 1, 8'h80, 8'h02, 8'hFF};
        tbl[26] = '{8'h82, 0, 8'h00, 0, 1,  0, 1, 8'h80, 8'h00, 8'hFF};
        tbl[27] = '{8'h00, 0, 8'h00, 0, 0,  1, 7, 8'h80, 8'h00, 8'hFF};
        tbl[28] = '{8'h00, 0, 8'h00, 1, 0,  0, 7, 8'h00, 8'h80, 8'hFF};
        tbl[29] = '{8'h00, 0, 8'h00, 0, 1,  0, 7, 8'h00, 8'h00, 8'hFF};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset req",  {7'd0, irq_req}, 8'h00);
        chk("reset vec",  {5'd0, irq_vec}, 8'h00);
        chk("reset pend", pending, 8'h00);
        chk("reset ins",  in_service, 8'h00);
        chk("reset mask", mask, 8'hFF);
        rst = 1'b0;

        foreach (tbl[i]) begin
            irq_in = tbl[i].irq; mask_we = tbl[i].we; mask_wdata = tbl[i].wd;
            irq_ack = tbl[i].ack; eoi = tbl[i].eo;
            step();
            chk($sformatf("row%0d req", i),  {7'd0, irq_req}, {7'd0, tbl[i].req});
            chk($sformatf("row%0d vec", i),  {5'd0, irq_vec}, {5'd0, tbl[i].vec});
            chk($sformatf("row%0d pend", i), pending, tbl[i].pend);
            chk($sformatf("row%0d ins", i),  in_service, tbl[i].ins);
            chk($sformatf("row%0d mask", i), mask, tbl[i].msk);
        end
        mask_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0;

        // Re-edge on bit 1 coincident with its ack: event must be kept.
        irq_in = 8'h02; step();
        irq_in = 8'h02; step();
        chk("setclr req", {7'd0, irq_req}, 8'h01);
        irq_in = 8'h00; step();
        irq_in = 8'h02; irq_ack = 1'b1; step();
        chk("setclr pend", pending, 8'h02);
        chk("setclr ins",  in_service, 8'h02);
        irq_ack = 1'b0; eoi = 1'b1; step();
        eoi = 1'b0; step();
        chk("rereq req", {7'd0, irq_req}, 8'h01);
        chk("rereq vec", {5'd0, irq_vec}, 8'h01);

        // Asynchronous reset in the middle of a request.
        #2 rst = 1'b1;
        #1;
        chk("async req",  {7'd0, irq_req}, 8'h00);
        chk("async vec",  {5'd0, irq_vec}, 8'h00);
        chk("async pend", pending, 8'h00);
        chk("async ins",  in_service, 8'h00);
        chk("async mask", mask, 8'hFF);
        irq_in = 8'h00;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk_model("post-rst");

        for (int n = 0; n < 1500; n++) begin
            irq_in     = 8'($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = 8'($urandom);
            irq_ack    = $urandom_range(1) == 1;
            eoi        = $urandom_range(2) == 0;
            step();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
